rr_arbiter8: RTL and testbench

Round-robin arbiter that shares one downstream resource among 8 requesters. It issues a registered one-hot grant with an encoded owner ID, holds the grant until the owner releases it or a hold timeout expires, and rotates priority so that no requester starves. It sits between the per-requester request lines and the shared datapath's select/enable logic. It replaces fixed-priority selection wherever fairness is required.

---
 rtl/rr_arbiter8.sv | 130 +++++++++++++
 tb/tb_rr_arbiter8.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a registered one-hot grant.
// A grant is held until done, a request drop, or the optional hold timeout.
module rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam bit         HOLD_ENABLED = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST    = HOLD_ENABLED ? 8'(HOLD_MAX - 1) : 8'd0;

    state_t     state;
    state_t     state_next;
    logic [2:0] ptr;
    logic [2:0] ptr_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [7:0] gnt_next;
    logic [2:0] gnt_id_next;
    logic       busy_next;
    logic       timeout_next;

    logic       found;
    logic [2:0] winner;
    logic [2:0] idx;
    logic       hold_expired;
    logic       released;

    // First requester at or after ptr, wrapping modulo 8.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = '0;
        for (int i = 0; i < 8; i++) begin
            idx = ptr + 3'(i);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        hold_expired = HOLD_ENABLED && (cnt == HOLD_LAST);
        released     = done || !req[gnt_id] || hold_expired;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            cnt     <= cnt_next;
            gnt     <= gnt_next;
            gnt_id  <= gnt_id_next;
            busy    <= busy_next;
            timeout <= timeout_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (en && found) state_next = GRANT;
            GRANT:   if (released)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Timeout is flagged only when the counter is the sole release cause.
    always_comb begin
        ptr_next     = ptr;
        cnt_next     = cnt;
        gnt_next     = gnt;
        gnt_id_next  = gnt_id;
        busy_next    = busy;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (en && found) begin
                    gnt_next    = 8'b1 << winner;
                    gnt_id_next = winner;
                    busy_next   = 1'b1;
                    cnt_next    = '0;
                    ptr_next    = winner + 3'd1;
                end else begin
                    gnt_next    = '0;
                    gnt_id_next = '0;
                    busy_next   = 1'b0;
                end
            end
            GRANT: begin
                if (released) begin
                    gnt_next     = '0;
                    gnt_id_next  = '0;
                    busy_next    = 1'b0;
                    timeout_next = hold_expired && !done && req[gnt_id];
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            default: begin
                gnt_next    = '0;
                gnt_id_next = '0;
                busy_next   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8: directed vector table, hand-written corner sequences
// and randomized traffic checked against an owner/pointer reference model.
module tb_rr_arbiter8;

    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    int   mOwner   = -1;
    int   mPtr     = 0;
    int   mCnt     = 0;
    logic mTimeout = 1'b0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] req;
        logic       done;
        logic [7:0] eGnt;
        logic [2:0] eId;
        logic       eBusy;
        logic       eTo;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    rr_arbiter8 #(.HOLD_MAX(HOLD)) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .req    (req),
        .done   (done),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .busy   (busy),
        .timeout(timeout)
    );

    // Reference model: who owns the resource, where the search starts, how long held.
    task automatic modelStep();
        bit dropped;
        bit expired;
        int c;
        if (rst) begin
            mOwner   = -1;
            mPtr     = 0;
            mCnt     = 0;
            mTimeout = 1'b0;
        end else if (mOwner < 0) begin
            mTimeout = 1'b0;
            if (en && req != 0) begin
                for (int k = 0; k < 8; k++) begin
                    c = (mPtr + k) % 8;
                    if (req[c]) begin
                        mOwner = c;
                        mPtr   = (c + 1) % 8;
                        mCnt   = 0;
                        break;
                    end
                end
            end
        end else begin
            dropped = !req[mOwner];
            expired = (HOLD != 0) && (mCnt == HOLD - 1);
            if (done || dropped || expired) begin
                mTimeout = expired && !done && !dropped;
                mOwner   = -1;
            end else begin
                mCnt     = mCnt + 1;
                mTimeout = 1'b0;
            end
        end
    endtask

    function automatic logic [7:0] modelGnt();
        return (mOwner < 0) ? 8'h00 : 8'(1 << mOwner);
    endfunction

    function automatic logic [2:0] modelId();
        return (mOwner < 0) ? 3'd0 : 3'(mOwner);
    endfunction

    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] q, input logic d);
        rst  = r;
        en   = e;
        req  = q;
        done = d;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] eg, input logic [2:0] ei,
                               input logic eb, input logic et);
        checks++;
        if (gnt !== eg || gnt_id !== ei || busy !== eb || timeout !== et) begin
            failures++;
            $display("[TB] FAIL %s: got gnt=%h id=%0d busy=%b timeout=%b, expected gnt=%h id=%0d busy=%b timeout=%b",
                     name, gnt, gnt_id, busy, timeout, eg, ei, eb, et);
        end
    endtask

    task automatic addVec(input logic r, input logic e, input logic [7:0] q, input logic d,
                          input logic [7:0] eg, input logic [2:0] ei, input logic eb, input logic et);
        vec_t v;
        v = '{r, e, q, d, eg, ei, eb, et};
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] rq;

        //     rst  en  req    done  gnt    id  busy to
        addVec(1, 0, 8'h00, 0, 8'h00, 0, 0, 0);
        addVec(0, 1, 8'h81, 0, 8'h01, 0, 1, 0);
        addVec(0, 1, 8'h81, 1, 8'h00, 0, 0, 0);
        addVec(0, 1, 8'h81, 0, 8'h80, 7, 1, 0);
        addVec(0, 1, 8'h81, 1, 8'h00, 0, 0, 0);
        addVec(0, 1, 8'h81, 0, 8'h01, 0, 1, 0);
        addVec(0, 1, 8'h81, 1, 8'h00, 0, 0, 0);
        addVec(0, 0, 8'hFF, 0, 8'h00, 0, 0, 0);
        addVec(0, 0, 8'hFF, 0, 8'h00, 0, 0, 0);
        addVec(0, 1, 8'h08, 0, 8'h08, 3, 1, 0);
        addVec(0, 0, 8'h08, 0, 8'h08, 3, 1, 0);
        addVec(0, 0, 8'h08, 0, 8'h08, 3, 1, 0);
        addVec(0, 0, 8'h08, 1, 8'h00, 0, 0, 0);
        addVec(0, 0, 8'hFF, 0, 8'h00, 0, 0, 0);
        addVec(0, 1, 8'hFF, 0, 8'h10, 4, 1, 0);
        addVec(0, 1, 8'hFF, 1, 8'h00, 0, 0, 0);
        addVec(0, 1, 8'hFF, 0, 8'h20, 5, 1, 0);
        addVec(0, 1, 8'h00, 0, 8'h00, 0, 0, 0);
        addVec(0, 1, 8'h00, 0, 8'h00, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].done);
            checkOutput($sformatf("vec%0d", i), vecs[i].eGnt, vecs[i].eId, vecs[i].eBusy, vecs[i].eTo);
        end

        // Forced release after HOLD cycles, then a done that ties with the counter.
        applyStimulus(1, 1, 8'h04, 0);
        checkOutput("to_reset", 8'h00, 0, 0, 0);
        applyStimulus(0, 1, 8'h04, 0);
        checkOutput("to_grant", 8'h04, 2, 1, 0);
        for (int k = 1; k < HOLD; k++) begin
            applyStimulus(0, 1, 8'h04, 0);
            checkOutput($sformatf("to_hold%0d", k), 8'h04, 2, 1, 0);
        end
        applyStimulus(0, 1, 8'h04, 0);
        checkOutput("to_fire", 8'h00, 0, 0, 1);
        applyStimulus(0, 1, 8'h04, 0);
        checkOutput("to_regrant", 8'h04, 2, 1, 0);
        for (int k = 1; k < HOLD; k++) begin
            applyStimulus(0, 1, 8'h04, 0);
            checkOutput($sformatf("tie_hold%0d", k), 8'h04, 2, 1, 0);
        end
        applyStimulus(0, 1, 8'h04, 1);
        checkOutput("tie_release", 8'h00, 0, 0, 0);

        // Reset in the middle of a grant, then an owner dropping its request.
        applyStimulus(0, 1, 8'hFF, 0);
        checkOutput("mid_grant", 8'h08, 3, 1, 0);
        applyStimulus(0, 1, 8'hFF, 0);
        checkOutput("mid_hold", 8'h08, 3, 1, 0);
        applyStimulus(1, 1, 8'hFF, 0);
        checkOutput("mid_reset", 8'h00, 0, 0, 0);
        applyStimulus(0, 1, 8'hFF, 0);
        checkOutput("post_reset", 8'h01, 0, 1, 0);
        applyStimulus(0, 1, 8'h00, 0);
        checkOutput("req_drop", 8'h00, 0, 0, 0);

        rq = 8'h00;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) rq = 8'($urandom);
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, rq,
                          $urandom_range(0, 7) == 0);
            checkOutput($sformatf("rand%0d", n), modelGnt(), modelId(), mOwner >= 0, mTimeout);
            checks++;
            if ($countones(gnt) > 1 || (gnt != 0 && gnt != (8'd1 << gnt_id)) || (gnt == 0 && gnt_id != 0)) begin
                failures++;
                $display("[TB] FAIL onehot%0d: got gnt=%h id=%0d, expected one-hot gnt matching id", n, gnt, gnt_id);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
